wb_arbiter: RTL and testbench

Parametrised writeback arbiter for the out-of-order pipeline. It takes results from `NUM_CH` execution channels (ALU, load/store, multiply, branch, ...) and grants at most one channel per cycle onto the single registered result bus (CDB). Losing channels are stalled through their `req_ready` line. Selection is either round-robin or fixed-priority with anti-starvation aging. The block sits between the functional-unit output stages and the reservation-station/ROB wakeup logic.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arbiter_rr_picker.sv | 36 +++
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

    localparam int MODE_RR   = 0;   // round-robin selection
    localparam int MODE_AGED = 1;   // fixed priority with anti-starvation aging

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// First-set-bit picker: scans req upward from start with wrap, returns one-hot grant + index.
// Latency: combinational.
// Backpressure: none; grant is zero when req is zero.
// Ports: req (request vector), start (scan origin), grant (one-hot), idx (winner index).
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   p;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int k = 0; k < N; k++) begin
            // start + k folded back into 0..N-1 (N need not be a power of two)
            p = int'(start) + k;
            if (p >= N) p = p - N;
            if (!found && req[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = IW'(p);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants at most one of NUM_CH result channels per cycle onto the registered CDB.
// Latency: grant same cycle, CDB value 1 cycle after the transfer.
// Backpressure: losers see req_ready low and must hold; flush and rst force req_ready to zero.
// Ports: clk/rst (sync, active-high); req_valid/req_tag/req_data in, req_ready out (one-hot);
//        flush in; cdb_valid/cdb_tag/cdb_data/cdb_ch out (registered).
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int MODE    = 0,
    parameter int AGE_MAX = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*TAG_W-1:0]    req_tag,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic                       flush,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_CH)-1:0]  cdb_ch
);

    localparam int IW = idx_w(NUM_CH);

    logic [NUM_CH-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              take;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [IW-1:0] rr_ptr;

            rr_picker #(.N(NUM_CH)) u_pick (
                .req   (req_valid),
                .start (rr_ptr),
                .grant (pick_gnt),
                .idx   (pick_idx)
            );

            // Winner's successor becomes top priority; no grant (incl. flush) holds the pointer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (take) begin
                    rr_ptr <= (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
        end else begin : g_aged
            localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);

            logic [7:0]        age [NUM_CH];
            logic [NUM_CH-1:0] aged;
            logic [NUM_CH-1:0] aged_gnt;
            logic [NUM_CH-1:0] valid_gnt;
            logic [IW-1:0]     aged_idx;
            logic [IW-1:0]     valid_idx;

            // Gate with valid so a channel that just dropped its request can never be readied.
            always_comb begin
                aged = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    aged[i] = req_valid[i] && (age[i] == AGE_LIM);
                end
            end

            rr_picker #(.N(NUM_CH)) u_pick_aged (
                .req   (aged),
                .start ('0),
                .grant (aged_gnt),
                .idx   (aged_idx)
            );

            rr_picker #(.N(NUM_CH)) u_pick_valid (
                .req   (req_valid),
                .start ('0),
                .grant (valid_gnt),
                .idx   (valid_idx)
            );

            assign pick_gnt = (|aged) ? aged_gnt : valid_gnt;
            assign pick_idx = (|aged) ? aged_idx : valid_idx;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < NUM_CH; i++) age[i] <= '0;
                end else if (!flush) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (req_valid[i] && !req_ready[i]) begin
                            age[i] <= (age[i] == AGE_LIM) ? AGE_LIM : age[i] + 8'd1;
                        end else begin
                            age[i] <= '0;
                        end
                    end
                end
            end
        end
    endgenerate

    assign req_ready = (rst || flush) ? '0 : pick_gnt;
    assign take      = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_ch    <= '0;
        end else begin
            cdb_valid <= take;
            if (take) begin
                cdb_tag  <= req_tag[int'(pick_idx)*TAG_W +: TAG_W];
                cdb_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                cdb_ch   <= pick_idx[$clog2(NUM_CH)-1:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: round-robin (4 ch), aged priority (4 ch, AGE_MAX 3), round-robin (2 ch).
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 4-channel round-robin instance
    logic [3:0]  valid_rr;
    logic [23:0] tag_rr;
    logic [127:0] data_rr;
    logic [3:0]  ready_rr;
    logic        flush_rr;
    logic        cv_rr;
    logic [5:0]  ct_rr;
    logic [31:0] cd_rr;
    logic [1:0]  cc_rr;

    // 4-channel aged instance
    logic [3:0]  valid_ag;
    logic [23:0] tag_ag;
    logic [127:0] data_ag;
    logic [3:0]  ready_ag;
    logic        cv_ag;
    logic [5:0]  ct_ag;
    logic [31:0] cd_ag;
    logic [1:0]  cc_ag;

    // 2-channel round-robin instance
    logic [1:0]  valid_2;
    logic [11:0] tag_2;
    logic [63:0] data_2;
    logic [1:0]  ready_2;
    logic        cv_2;
    logic [5:0]  ct_2;
    logic [31:0] cd_2;
    logic        cc_2;

    wb_arbiter #(.NUM_CH(4), .DATA_W(32), .TAG_W(6), .MODE(0), .AGE_MAX(7)) dut_rr (
        .clk(clk), .rst(rst), .req_valid(valid_rr), .req_tag(tag_rr), .req_data(data_rr),
        .req_ready(ready_rr), .flush(flush_rr), .cdb_valid(cv_rr), .cdb_tag(ct_rr),
        .cdb_data(cd_rr), .cdb_ch(cc_rr)
    );

    wb_arbiter #(.NUM_CH(4), .DATA_W(32), .TAG_W(6), .MODE(1), .AGE_MAX(3)) dut_ag (
        .clk(clk), .rst(rst), .req_valid(valid_ag), .req_tag(tag_ag), .req_data(data_ag),
        .req_ready(ready_ag), .flush(1'b0), .cdb_valid(cv_ag), .cdb_tag(ct_ag),
        .cdb_data(cd_ag), .cdb_ch(cc_ag)
    );

    wb_arbiter #(.NUM_CH(2), .DATA_W(32), .TAG_W(6), .MODE(0), .AGE_MAX(7)) dut_2 (
        .clk(clk), .rst(rst), .req_valid(valid_2), .req_tag(tag_2), .req_data(data_2),
        .req_ready(ready_2), .flush(1'b0), .cdb_valid(cv_2), .cdb_tag(ct_2),
        .cdb_data(cd_2), .cdb_ch(cc_2)
    );

    task automatic test_reset();
        rst = 1'b1; flush_rr = 1'b0;
        valid_rr = '0; tag_rr = '0; data_rr = '0;
        valid_ag = '0; tag_ag = '0; data_ag = '0;
        valid_2  = '0; tag_2  = '0; data_2  = '0;
        repeat (2) @(posedge clk);
        #1 valid_rr = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (ready_rr !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready: got %b want 0000", ready_rr);
        end
        @(posedge clk);
        #1 rst = 1'b0; valid_rr = '0;
        @(negedge clk);
        n_cmp++;
        if ({cv_rr, ct_rr, cd_rr, cc_rr} !== '0) begin
            n_err++; $display("FAIL reset_cdb: got v=%b t=%0d d=%h c=%0d want all 0", cv_rr, ct_rr, cd_rr, cc_rr);
        end
    endtask

    task automatic test_single();
        @(posedge clk);
        #1 valid_rr = 4'b0100; tag_rr = '0; data_rr = '0;
        tag_rr[12 +: 6] = 6'd5; data_rr[64 +: 32] = 32'hA5;
        @(negedge clk);
        n_cmp++;
        if (ready_rr !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b want 0100", ready_rr);
        end
    endtask

    // Entered right after the single-channel grant: cdb_valid=1 next cycle and pointer at 3.
    task automatic test_mid_reset();
        @(posedge clk);
        #1 rst = 1'b1; valid_rr = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tag_rr[i*6 +: 6] = 6'(10 + i); data_rr[i*32 +: 32] = 32'h100 + i;
        end
        @(negedge clk);
        n_cmp++;
        if (cv_rr !== 1'b1 || ct_rr !== 6'd5 || cd_rr !== 32'hA5 || cc_rr !== 2'd2) begin
            n_err++; $display("FAIL single_cdb: got v=%b t=%0d d=%h c=%0d want 1/5/a5/2", cv_rr, ct_rr, cd_rr, cc_rr);
        end
        n_cmp++;
        if (ready_rr !== 4'b0000) begin
            n_err++; $display("FAIL midrst_ready: got %b want 0000", ready_rr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cv_rr, ct_rr, cd_rr, cc_rr} !== '0) begin
            n_err++; $display("FAIL midrst_cdb: got v=%b t=%0d d=%h c=%0d want all 0", cv_rr, ct_rr, cd_rr, cc_rr);
        end
    endtask

    // Continues with all four valid; first grant must be channel 0 (pointer cleared by reset).
    task automatic test_round_robin();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ready_rr !== 4'(1 << (k % 4))) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, ready_rr, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                n_cmp++;
                if (cv_rr !== 1'b1 || cc_rr !== 2'((k - 1) % 4) || ct_rr !== 6'(10 + (k - 1) % 4)) begin
                    n_err++; $display("FAIL rr_cdb[%0d]: got v=%b c=%0d t=%0d want 1/%0d/%0d", k, cv_rr, cc_rr, ct_rr, (k - 1) % 4, 10 + (k - 1) % 4);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (cv_rr !== 1'b1 || cc_rr !== 2'd3 || cd_rr !== 32'h103) begin
            n_err++; $display("FAIL rr_cdb_last: got v=%b c=%0d d=%h want 1/3/103", cv_rr, cc_rr, cd_rr);
        end
    endtask

    task automatic test_flush();
        // two more grants (0,1) bring the pointer to 2
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ready_rr !== 4'(1 << k)) begin
                n_err++; $display("FAIL flush_pre[%0d]: got %b want %b", k, ready_rr, 4'(1 << k));
            end
            @(posedge clk);
            @(negedge clk);
        end
        flush_rr = 1'b1;
        #1;
        n_cmp++;
        if (ready_rr !== 4'b0000) begin
            n_err++; $display("FAIL flush_ready: got %b want 0000", ready_rr);
        end
        @(posedge clk);
        #1 flush_rr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cv_rr !== 1'b0) begin
            n_err++; $display("FAIL flush_cdb: got v=%b want 0", cv_rr);
        end
        n_cmp++;
        if (ready_rr !== 4'b0100) begin
            n_err++; $display("FAIL flush_after: got %b want 0100", ready_rr);
        end
        @(posedge clk);
        #1 valid_rr = '0;
        @(negedge clk);
        n_cmp++;
        if (cv_rr !== 1'b1 || cc_rr !== 2'd2) begin
            n_err++; $display("FAIL flush_resume_cdb: got v=%b c=%0d want 1/2", cv_rr, cc_rr);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cv_rr !== 1'b0) begin
            n_err++; $display("FAIL cdb_fall: got v=%b want 0", cv_rr);
        end
    endtask

    task automatic test_aging();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                  4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [1:0] exp_c [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        @(posedge clk);
        #1 valid_ag = 4'b0011;
        tag_ag[0 +: 6] = 6'd20; tag_ag[6 +: 6] = 6'd21;
        data_ag[0 +: 32] = 32'hDEAD0000; data_ag[32 +: 32] = 32'hDEAD0001;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ready_ag !== exp_g[k]) begin
                n_err++; $display("FAIL age_grant[%0d]: got %b want %b", k, ready_ag, exp_g[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (cv_ag !== 1'b1 || cc_ag !== exp_c[k-1] || ct_ag !== 6'(20 + exp_c[k-1])) begin
                    n_err++; $display("FAIL age_cdb[%0d]: got v=%b c=%0d t=%0d want 1/%0d/%0d", k, cv_ag, cc_ag, ct_ag, exp_c[k-1], 20 + exp_c[k-1]);
                end
            end
            @(posedge clk);
        end
        #1 valid_ag = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (ready_ag !== 4'b0100) begin
            n_err++; $display("FAIL age_single: got %b want 0100", ready_ag);
        end
        @(posedge clk);
        #1 valid_ag = '0;
    endtask

    task automatic test_two_channel();
        @(posedge clk);
        #1 valid_2 = 2'b11; tag_2 = {6'd31, 6'd30}; data_2 = {32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ready_2 !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL two_grant[%0d]: got %b want %b", k, ready_2, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (k > 0) begin
                n_cmp++;
                if (cv_2 !== 1'b1 || cc_2 !== 1'((k - 1) % 2) || cd_2 !== (((k - 1) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222)) begin
                    n_err++; $display("FAIL two_cdb[%0d]: got v=%b c=%0d d=%h", k, cv_2, cc_2, cd_2);
                end
            end
            @(posedge clk);
        end
        #1 valid_2 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_mid_reset();
        test_round_robin();
        test_flush();
        test_aging();
        test_two_channel();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
